// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions: memory-op aluop encodings, MEM-stage FSM state type
// and small decode helpers used by the decode, EX and MEM stages.
package mem_stage_pkg;

    localparam logic [7:0] ALU_LB  = 8'b1110_0000;
    localparam logic [7:0] ALU_LH  = 8'b1110_0001;
    localparam logic [7:0] ALU_LW  = 8'b1110_0011;
    localparam logic [7:0] ALU_LBU = 8'b1110_0100;
    localparam logic [7:0] ALU_LHU = 8'b1110_0101;
    localparam logic [7:0] ALU_SB  = 8'b1110_1000;
    localparam logic [7:0] ALU_SH  = 8'b1110_1001;
    localparam logic [7:0] ALU_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == ALU_LB) || (op == ALU_LBU) || (op == ALU_LH) ||
               (op == ALU_LHU) || (op == ALU_LW);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-bus bundle between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Load data lane extraction (big-endian) with sign/zero extension to 32 bits.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane pick: offset 0 is the most significant byte of the word.
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_s = rdata_i[31:24];
            2'd1:    byte_s = rdata_i[23:16];
            2'd2:    byte_s = rdata_i[15:8];
            2'd3:    byte_s = rdata_i[7:0];
            default: byte_s = 8'h00;
        endcase
        half_s = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    end

    // Extension by load flavour.
    always_comb begin
        case (aluop_i)
            ALU_LB:  data_o = {{24{byte_s[7]}}, byte_s};
            ALU_LBU: data_o = {24'h000000, byte_s};
            ALU_LH:  data_o = {{16{half_s[15]}}, half_s};
            ALU_LHU: data_o = {16'h0000, half_s};
            ALU_LW:  data_o = rdata_i;
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-bus accesses, stalls until ack, aligns loads.
// Optional MEM_ALIGN_CHECK_EN adds misaligned-access suppression and misalign_o.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    mem_stage_if.master dbus,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq
);

    mem_state_e  state_q, state_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_op_s, store_op_s, mem_op_s, misalign_s, access_s;
    logic [3:0]  sel_s;
    logic [31:0] store_wdata_s, load_ext_s;
    logic        unused_stall_s;

    assign unused_stall_s = ^{stall[5:4], stall[2:0]};
    assign load_op_s  = is_load_op(mem_aluop);
    assign store_op_s = is_store_op(mem_aluop);
    assign mem_op_s   = load_op_s | store_op_s;
    // DONE means this held instruction already completed its single access.
    assign access_s   = mem_op_s & ~misalign_s & (state_q != ST_DONE);

`ifdef MEM_ALIGN_CHECK_EN
    // Halfwords need addr[0]=0, words need addr[1:0]=0.
    always_comb begin
        case (mem_aluop)
            ALU_LH, ALU_LHU, ALU_SH: misalign_s = mem_mem_addr[0];
            ALU_LW, ALU_SW:          misalign_s = |mem_mem_addr[1:0];
            default:                 misalign_s = 1'b0;
        endcase
    end
`else
    assign misalign_s = 1'b0;
`endif

    mem_load_align u_load_align (
        .aluop_i   (mem_aluop),
        .addr_lo_i (mem_mem_addr[1:0]),
        .rdata_i   (dbus.dbus_rdata),
        .data_o    (load_ext_s)
    );

    // Store byte-enables and lane-replicated write data.
    always_comb begin
        case (mem_aluop)
            ALU_LB, ALU_LBU, ALU_SB: sel_s = 4'b1000 >> mem_mem_addr[1:0];
            ALU_LH, ALU_LHU, ALU_SH: sel_s = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
            ALU_LW, ALU_SW:          sel_s = 4'b1111;
            default:                 sel_s = 4'b0000;
        endcase
        case (mem_aluop)
            ALU_SB:  store_wdata_s = {4{mem_reg2[7:0]}};
            ALU_SH:  store_wdata_s = {2{mem_reg2[15:0]}};
            default: store_wdata_s = mem_reg2;
        endcase
    end

    // State and latched load data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            load_data_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
        end
    end

    // Next state: an ack completes the access; a held pipe parks in DONE.
    always_comb begin
        state_d     = state_q;
        load_data_d = load_data_q;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (access_s && dbus.dbus_ack) begin
                    load_data_d = load_ext_s;
                    state_d     = stall[3] ? ST_DONE : ST_IDLE;
                end else if (access_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: state_d = stall[3] ? ST_DONE : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: pass-through with load/store overrides; all zero in reset.
    always_comb begin
        wd_o            = 5'h00;
        wreg_o          = 1'b0;
        wdata_o         = 32'h0000_0000;
        whilo_o         = 1'b0;
        hi_o            = 32'h0000_0000;
        lo_o            = 32'h0000_0000;
        stallreq        = 1'b0;
        dbus.dbus_req   = 1'b0;
        dbus.dbus_we    = 1'b0;
        dbus.dbus_sel   = 4'b0000;
        dbus.dbus_addr  = 32'h0000_0000;
        dbus.dbus_wdata = 32'h0000_0000;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_o      = rst ? 1'b0 : misalign_s;
`endif
        if (!rst) begin
            wd_o    = mem_wd;
            wreg_o  = mem_wreg & ~store_op_s & ~misalign_s;
            whilo_o = mem_whilo;
            hi_o    = mem_hi;
            lo_o    = mem_lo;
            if (load_op_s) begin
                wdata_o = (state_q == ST_DONE) ? load_data_q : load_ext_s;
            end else begin
                wdata_o = mem_wdata;
            end
            if (access_s) begin
                dbus.dbus_req   = 1'b1;
                dbus.dbus_we    = store_op_s;
                dbus.dbus_sel   = sel_s;
                dbus.dbus_addr  = {mem_mem_addr[31:2], 2'b00};
                dbus.dbus_wdata = store_wdata_s;
                stallreq        = ~dbus.dbus_ack;
            end else begin
                stallreq = 1'b0;
            end
        end else begin
            stallreq = 1'b0;
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 stall  in  6  pipeline stall vector from ctrl; bit 3 = EX/MEM register held.
REQ-003 mem_wd, mem_wreg, mem_wdata  in  5/1/32  GPR write target, enable, ALU result from EX/MEM register.
REQ-004 mem_whilo, mem_hi, mem_lo  in  1/32/32  HI/LO write enable and values.
REQ-005 mem_aluop, mem_mem_addr, mem_reg2  in  8/32/32  operation code, effective address, store data.
REQ-006 wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o  out  5/1/32/1/32/32  results to MEM/WB register.
REQ-007 dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata  out  1/1/4/32/32  data-bus request.
REQ-008 dbus_ack, dbus_rdata  in  1/32  data-bus completion and read data.
REQ-009 stallreq  out  1  stall request to ctrl while a memory access is pending.

Function
REQ-010 Non-memory aluop: all inputs pass to outputs combinationally; dbus_req=0; stallreq=0.
REQ-011 Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW; only loads drive wdata_o from memory; stores force wreg_o=0.
REQ-012 dbus_addr = {mem_mem_addr[31:2],2'b00}; big-endian lanes: addr[1:0]=0 selects bits 31:24.
REQ-013 dbus_sel: byte ops 1000/0100/0010/0001 for addr[1:0]=0..3; half ops 1100 (addr[1]=0) / 0011 (addr[1]=1); word 1111.
REQ-014 dbus_wdata: SB replicates reg2[7:0] to all 4 lanes; SH replicates reg2[15:0] to both halves; SW uses reg2.
REQ-015 Loads extract the selected lane; LB/LH sign-extend, LBU/LHU zero-extend, to 32 bits.
REQ-016 FSM states IDLE, WAIT, DONE; dbus_req, dbus_we, dbus_sel valid only while dbus_req=1.
REQ-017 IDLE, memory op, dbus_ack=0: dbus_req=1, stallreq=1, next WAIT.
REQ-018 IDLE or WAIT, memory op, dbus_ack=1: zero further wait; wdata_o from dbus_rdata this cycle; stallreq=0; latch extracted data; next DONE if stall[3]=1, else IDLE.
REQ-019 WAIT, dbus_ack=0: hold dbus_req=1, stallreq=1, bus fields stable.
REQ-020 DONE: dbus_req=0, stallreq=0, wdata_o from latched data (no re-issue while another stall source holds the pipe); next IDLE when stall[3]=0.
REQ-021 dbus_ack while dbus_req=0 is ignored.

Reset
REQ-022 While rst=1 every output is 0, state IDLE, latched data 0; reset in WAIT abandons the access with no bus activity after the reset cycle.

Configuration
REQ-023 MEM_ALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 suppresses dbus_req, forces wreg_o=0, asserts extra output misalign_o=1 for that cycle; undefined: no misalign_o port, lane selection uses addr bits as-is, no check.

Structure
REQ-024 aluop encodings for the eight memory ops and the FSM state type live in the shared CPU definitions package used by the decode and EX stages.
REQ-025 Load lane extraction/extension is one sub-module, mem_load_align; store lane/sel generation stays inline.

Verification
REQ-026 LW addr 0x100, ack 3 cycles later, rdata 0xDEADBEEF -> stallreq high 3 cycles, wdata_o=0xDEADBEEF, wreg_o=1, sel 1111.
REQ-027 LB addr 0x103, ack same cycle, rdata 0x112233F0 -> stallreq never high, wdata_o=0xFFFFFFF0; LBU -> 0x000000F0.
REQ-028 SH addr 0x202, reg2 0x0000ABCD -> dbus_we=1, sel 0011, dbus_wdata=0xABCDABCD, wreg_o=0.
REQ-029 LH ack while stall[3]=1 held 2 more cycles, then rdata changes to 0 -> DONE holds wdata_o at latched value, dbus_req=0, single request only.
REQ-030 rst asserted in WAIT -> dbus_req=0 and stallreq=0 the same cycle, state IDLE; with MEM_ALIGN_CHECK_EN, LW addr 0x101 -> misalign_o=1, dbus_req=0.
